// File: rtl/leaf_stream_packetizer.sv
// Leaf stream packetizer.
// Turns NUM_PORTS user AXI-stream outputs into BFT packets. Each port has a
// two-entry skid FIFO. A round-robin arbiter picks the next port, and each
// packet carries the port's static destination and a per-port sequence
// number. Per-port credit counters stop a port once the destination
// receive buffer is full.
module leaf_stream_packetizer #(
  parameter int NUM_PORTS             = 3,
  parameter int PAYLOAD_BITS          = 32,
  parameter int PACKET_BITS           = 49,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  input  logic [NUM_PORTS*PAYLOAD_BITS-1:0] in_tdata,
  input  logic [NUM_PORTS-1:0]              in_tvalid,
  output logic [NUM_PORTS-1:0]              in_tready,
  input  logic [NUM_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
  input  logic                              credit_vld,
  input  logic [NUM_PORT_BITS-1:0]          credit_port,
  output logic [PACKET_BITS-1:0]            dout_leaf_interface2bft,
  input  logic                              bft_ready
);

  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CRED_W = NUM_ADDR_BITS + 1;
  localparam int CFG_W  = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam logic [CRED_W-1:0]        CREDIT_INIT = {1'b1, {NUM_ADDR_BITS{1'b0}}};
  localparam logic [NUM_ADDR_BITS-1:0] SEQ_ONE     = {{(NUM_ADDR_BITS-1){1'b0}}, 1'b1};

  logic [PAYLOAD_BITS-1:0]  slot0_r [NUM_PORTS];
  logic [PAYLOAD_BITS-1:0]  slot1_r [NUM_PORTS];
  logic [PAYLOAD_BITS-1:0]  slot0_nxt_s [NUM_PORTS];
  logic [PAYLOAD_BITS-1:0]  slot1_nxt_s [NUM_PORTS];
  logic [1:0]               fifo_cnt_r [NUM_PORTS];
  logic [1:0]               fifo_cnt_nxt_s [NUM_PORTS];
  logic [CRED_W-1:0]        credit_r [NUM_PORTS];
  logic [CRED_W-1:0]        credit_nxt_s [NUM_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_r [NUM_PORTS];
  logic [NUM_PORTS-1:0]     push_s;
  logic [NUM_PORTS-1:0]     pop_s;
  logic [NUM_PORTS-1:0]     eligible_s;
  logic [NUM_PORTS-1:0]     in_tready_r;
  logic [IDX_W-1:0]         ptr_r;
  logic [IDX_W-1:0]         ptr_nxt_s;
  logic [IDX_W-1:0]         grant_idx_s;
  logic                     grant_vld_s;
  logic [PACKET_BITS-1:0]   dout_r;
  logic [PACKET_BITS-1:0]   dout_nxt_s;

  assign in_tready               = in_tready_r;
  assign dout_leaf_interface2bft = dout_r;

  // A port may compete only when it holds data and still has credit.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible_s[i] = (fifo_cnt_r[i] != 2'd0) && (credit_r[i] != {CRED_W{1'b0}});
    end
  end

  // Round-robin search from the pointer; grants only when the output slot can take a packet.
  always_comb begin
    int cand;
    cand        = 0;
    grant_vld_s = 1'b0;
    grant_idx_s = {IDX_W{1'b0}};
    ptr_nxt_s   = ptr_r;
    if (!dout_r[PACKET_BITS-1] || bft_ready) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = (int'(ptr_r) + k) % NUM_PORTS;
        if (!grant_vld_s && eligible_s[cand]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = IDX_W'(cand);
        end else begin
          grant_idx_s = grant_idx_s;
        end
      end
    end else begin
      grant_vld_s = 1'b0;
    end
    if (grant_vld_s) begin
      ptr_nxt_s = IDX_W'((int'(grant_idx_s) + 1) % NUM_PORTS);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Skid FIFO next state: handshake, occupancy and the two slot contents.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      push_s[i]         = in_tvalid[i] & in_tready_r[i];
      pop_s[i]          = grant_vld_s && (int'(grant_idx_s) == i);
      fifo_cnt_nxt_s[i] = fifo_cnt_r[i] + {1'b0, push_s[i]} - {1'b0, pop_s[i]};
      slot0_nxt_s[i]    = slot0_r[i];
      slot1_nxt_s[i]    = slot1_r[i];
      if (pop_s[i]) begin
        slot0_nxt_s[i] = slot1_r[i];
      end else begin
        slot0_nxt_s[i] = slot0_r[i];
      end
      if (push_s[i]) begin
        if ((fifo_cnt_r[i] - {1'b0, pop_s[i]}) == 2'd0) begin
          slot0_nxt_s[i] = in_tdata[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        end else begin
          slot1_nxt_s[i] = in_tdata[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
      end else begin
        slot1_nxt_s[i] = slot1_nxt_s[i];
      end
    end
  end

  // Credit update: issue costs one, a return pulse adds a block; saturate at the buffer size.
  always_comb begin
    int sum;
    sum = 32'sd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      credit_nxt_s[i] = credit_r[i];
      sum = int'(credit_r[i])
          - (pop_s[i] ? 32'sd1 : 32'sd0)
          + ((credit_vld && (int'(credit_port) == i)) ? FREESPACE_UPDATE_SIZE : 32'sd0);
      if (sum > int'(CREDIT_INIT)) begin
        credit_nxt_s[i] = CREDIT_INIT;
      end else begin
        credit_nxt_s[i] = CRED_W'(sum);
      end
    end
  end

  // Output packet: load on grant, hold under back-pressure, otherwise empty.
  always_comb begin
    dout_nxt_s = {PACKET_BITS{1'b0}};
    if (grant_vld_s) begin
      dout_nxt_s = {1'b1,
                    dest_cfg[int'(grant_idx_s)*CFG_W +: CFG_W],
                    seq_r[grant_idx_s],
                    1'b0,
                    slot0_r[grant_idx_s]};
    end else if (dout_r[PACKET_BITS-1] && !bft_ready) begin
      dout_nxt_s = dout_r;
    end else begin
      dout_nxt_s = {PACKET_BITS{1'b0}};
    end
  end

  // Shared state: arbitration pointer and output packet register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_r  <= {IDX_W{1'b0}};
      dout_r <= {PACKET_BITS{1'b0}};
    end else begin
      ptr_r  <= ptr_nxt_s;
      dout_r <= dout_nxt_s;
    end
  end

  // Per-port state: FIFO slots and occupancy, ready, credit and sequence number.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        slot0_r[i]     <= {PAYLOAD_BITS{1'b0}};
        slot1_r[i]     <= {PAYLOAD_BITS{1'b0}};
        fifo_cnt_r[i]  <= 2'd0;
        in_tready_r[i] <= 1'b0;
        credit_r[i]    <= CREDIT_INIT;
        seq_r[i]       <= {NUM_ADDR_BITS{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        slot0_r[i]     <= slot0_nxt_s[i];
        slot1_r[i]     <= slot1_nxt_s[i];
        fifo_cnt_r[i]  <= fifo_cnt_nxt_s[i];
        in_tready_r[i] <= (fifo_cnt_nxt_s[i] < 2'd2);
        credit_r[i]    <= credit_nxt_s[i];
        if (pop_s[i]) begin
          seq_r[i] <= seq_r[i] + SEQ_ONE;
        end else begin
          seq_r[i] <= seq_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Self-checking bench for leaf_stream_packetizer. The reference model keeps
// one queue of accepted beats per port, plus the credit, sequence number and
// round-robin pointer as plain integers. It predicts dout and in_tready for
// every cycle.
module tb_leaf_stream_packetizer;
  localparam int NP = 3;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic [NP*32-1:0] in_tdata = '0;
  logic [NP-1:0] in_tvalid = '0;
  logic [NP-1:0] in_tready;
  logic [NP*8-1:0] dest_cfg = {8'hA7, 8'h13, 8'h52};
  logic          credit_vld = 1'b0;
  logic [3:0]    credit_port = 4'd0;
  logic [48:0]   dout;
  logic          bft_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] mq [NP][$];
  int          m_credit [NP];
  int          m_seq [NP];
  int          m_ptr;
  logic [48:0] exp_dout;
  logic [NP-1:0] exp_ready;

  always #5 ap_clk = ~ap_clk;

  leaf_stream_packetizer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tready(in_tready), .dest_cfg(dest_cfg), .credit_vld(credit_vld),
    .credit_port(credit_port), .dout_leaf_interface2bft(dout), .bft_ready(bft_ready)
  );

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      mq[p].delete();
      m_credit[p] = 128;
      m_seq[p] = 0;
    end
    m_ptr = 0;
    exp_dout = '0;
    exp_ready = '0;
  endtask

  // One clock edge of the model, using the inputs as they stood before the edge.
  task automatic model_step();
    int g;
    int p;
    int c;
    logic [48:0] nd;
    g = -1;
    if (!exp_dout[48] || bft_ready) begin
      for (int k = 0; k < NP; k++) begin
        p = (m_ptr + k) % NP;
        if (g < 0 && mq[p].size() > 0 && m_credit[p] > 0) g = p;
      end
    end
    if (g >= 0) begin
      nd = {1'b1, dest_cfg[8*g +: 8], 7'(m_seq[g]), 1'b0, mq[g][0]};
      void'(mq[g].pop_front());
      m_seq[g] = (m_seq[g] + 1) % 128;
      m_ptr = (g + 1) % NP;
    end else if (exp_dout[48] && !bft_ready) begin
      nd = exp_dout;
    end else begin
      nd = '0;
    end
    exp_dout = nd;
    for (int q = 0; q < NP; q++) begin
      c = m_credit[q] - ((q == g) ? 1 : 0) + ((credit_vld && credit_port == q) ? 64 : 0);
      if (c > 128) c = 128;
      m_credit[q] = c;
    end
    for (int q = 0; q < NP; q++) begin
      if (in_tvalid[q] && exp_ready[q]) mq[q].push_back(in_tdata[32*q +: 32]);
    end
    for (int q = 0; q < NP; q++) exp_ready[q] = (mq[q].size() < 2);
  endtask

  task automatic tick();
    @(posedge ap_clk);
    if (ap_rst_n) model_step();
    @(negedge ap_clk);
  endtask

  task automatic rand_data();
    for (int p = 0; p < NP; p++) in_tdata[32*p +: 32] = $urandom();
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    in_tvalid = '0;
    credit_vld = 1'b0;
    model_reset();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge ap_clk);
    checks++; if (dout !== 49'd0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (in_tready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", in_tready); end
    ap_rst_n = 1'b1;
    tick();
    checks++; if (in_tready !== 3'b111) begin errors++; $display("FAIL reset_ready_rise got=%b exp=111", in_tready); end
    checks++; if (dout !== 49'd0) begin errors++; $display("FAIL reset_dout_idle got=%h exp=0", dout); end
  endtask

  task automatic test_single_beat();
    logic [48:0] want;
    want = {1'b1, 4'h5, 4'h2, 7'd0, 1'b0, 32'hDEADBEEF};
    bft_ready = 1'b1;
    in_tdata[31:0] = 32'hDEADBEEF;
    in_tvalid = 3'b001;
    tick();
    in_tvalid = 3'b000;
    checks++; if (dout !== 49'd0) begin errors++; $display("FAIL single_accept_edge got=%h exp=0", dout); end
    tick();
    checks++; if (dout !== want) begin errors++; $display("FAIL single_pkt got=%h exp=%h", dout, want); end
    checks++; if (dout !== exp_dout) begin errors++; $display("FAIL single_model got=%h exp=%h", dout, exp_dout); end
    tick();
    checks++; if (dout !== 49'd0) begin errors++; $display("FAIL single_clear got=%h exp=0", dout); end
  endtask

  task automatic test_round_robin();
    int prev;
    int idx;
    bit seen;
    prev = -1;
    seen = 1'b0;
    bft_ready = 1'b1;
    in_tvalid = 3'b111;
    for (int c = 0; c < 30; c++) begin
      rand_data();
      tick();
      checks++; if (dout !== exp_dout) begin errors++; $display("FAIL rr_dout cyc=%0d got=%h exp=%h", c, dout, exp_dout); end
      checks++; if (in_tready !== exp_ready) begin errors++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, in_tready, exp_ready); end
      if (dout[48]) begin
        idx = (dout[43:40] == 4'h2) ? 0 : (dout[43:40] == 4'h3) ? 1 : 2;
        if (prev >= 0) begin
          checks++;
          if (idx != (prev + 1) % NP) begin errors++; $display("FAIL rr_order cyc=%0d got=%0d exp=%0d", c, idx, (prev + 1) % NP); end
        end
        prev = idx;
        seen = 1'b1;
      end else if (seen) begin
        checks++; errors++; $display("FAIL rr_gap cyc=%0d got=0 exp=valid", c);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [48:0] held;
    bft_ready = 1'b0;
    held = dout;
    checks++; if (held[48] !== 1'b1) begin errors++; $display("FAIL bp_pending got=%b exp=1", held[48]); end
    for (int c = 0; c < 5; c++) begin
      rand_data();
      tick();
      checks++; if (dout !== held) begin errors++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c, dout, held); end
      checks++; if (dout !== exp_dout) begin errors++; $display("FAIL bp_model cyc=%0d got=%h exp=%h", c, dout, exp_dout); end
    end
    checks++; if (in_tready !== 3'b000) begin errors++; $display("FAIL bp_full_ready got=%b exp=000", in_tready); end
    bft_ready = 1'b1;
    in_tvalid = 3'b000;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++; if (dout !== exp_dout) begin errors++; $display("FAIL bp_drain cyc=%0d got=%h exp=%h", c, dout, exp_dout); end
    end
    checks++; if (dout !== 49'd0) begin errors++; $display("FAIL bp_empty got=%h exp=0", dout); end
    checks++; if (in_tready !== 3'b111) begin errors++; $display("FAIL bp_ready_back got=%b exp=111", in_tready); end
  endtask

  task automatic test_credit_exhaust();
    int pk;
    int first_seq;
    do_reset();
    bft_ready = 1'b1;
    in_tvalid = 3'b010;
    pk = 0;
    for (int c = 0; c < 140; c++) begin
      rand_data();
      tick();
      if (dout[48]) pk++;
      checks++; if (dout !== exp_dout) begin errors++; $display("FAIL cred_dout cyc=%0d got=%h exp=%h", c, dout, exp_dout); end
    end
    checks++; if (pk != 128) begin errors++; $display("FAIL cred_count got=%0d exp=128", pk); end
    checks++; if (in_tready[1] !== 1'b0) begin errors++; $display("FAIL cred_ready got=%b exp=0", in_tready[1]); end
    credit_vld = 1'b1;
    credit_port = 4'd1;
    pk = 0;
    first_seq = -1;
    for (int c = 0; c < 80; c++) begin
      rand_data();
      tick();
      credit_vld = 1'b0;
      if (dout[48]) begin
        if (first_seq < 0) first_seq = int'(dout[39:33]);
        pk++;
      end
      checks++; if (dout !== exp_dout) begin errors++; $display("FAIL cred_refill cyc=%0d got=%h exp=%h", c, dout, exp_dout); end
    end
    checks++; if (pk != 64) begin errors++; $display("FAIL cred_refill_count got=%0d exp=64", pk); end
    checks++; if (first_seq != 0) begin errors++; $display("FAIL cred_seq_wrap got=%0d exp=0", first_seq); end
  endtask

  task automatic test_credit_saturate();
    int pk;
    bit pulsed;
    do_reset();
    bft_ready = 1'b1;
    in_tvalid = 3'b100;
    pk = 0;
    pulsed = 1'b0;
    for (int c = 0; c < 200; c++) begin
      rand_data();
      tick();
      credit_vld = 1'b0;
      if (dout[48]) pk++;
      checks++; if (dout !== exp_dout) begin errors++; $display("FAIL sat_dout cyc=%0d got=%h exp=%h", c, dout, exp_dout); end
      if (pk == 28 && !pulsed) begin
        pulsed = 1'b1;
        credit_vld = 1'b1;
        credit_port = 4'd2;
      end
    end
    checks++; if (pk != 157) begin errors++; $display("FAIL sat_count got=%0d exp=157", pk); end
    checks++; if (in_tready[2] !== 1'b0) begin errors++; $display("FAIL sat_ready got=%b exp=0", in_tready[2]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_data();
      in_tvalid = NP'($urandom());
      bft_ready = ($urandom_range(0, 3) != 0);
      credit_vld = ($urandom_range(0, 7) == 0);
      credit_port = 4'($urandom_range(0, 4));
      tick();
      checks++; if (dout !== exp_dout) begin errors++; $display("FAIL rnd_dout cyc=%0d got=%h exp=%h", c, dout, exp_dout); end
      checks++; if (in_tready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, in_tready, exp_ready); end
    end
    credit_vld = 1'b0;
  endtask

  task automatic test_async_reset();
    bit seen;
    in_tvalid = 3'b111;
    bft_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      rand_data();
      tick();
    end
    checks++; if (dout[48] !== 1'b1) begin errors++; $display("FAIL arst_pending got=%b exp=1", dout[48]); end
    #3;
    ap_rst_n = 1'b0;
    #1;
    checks++; if (dout !== 49'd0) begin errors++; $display("FAIL arst_dout got=%h exp=0", dout); end
    checks++; if (in_tready !== 3'b000) begin errors++; $display("FAIL arst_ready got=%b exp=000", in_tready); end
    model_reset();
    in_tvalid = 3'b000;
    bft_ready = 1'b1;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    in_tvalid = 3'b001;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      rand_data();
      tick();
      checks++; if (dout !== exp_dout) begin errors++; $display("FAIL arst_model cyc=%0d got=%h exp=%h", c, dout, exp_dout); end
      if (dout[48] && !seen) begin
        seen = 1'b1;
        checks++; if (dout[39:33] !== 7'd0) begin errors++; $display("FAIL arst_seq got=%0d exp=0", dout[39:33]); end
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL arst_first_pkt got=none exp=packet within 10 cycles"); end
    in_tvalid = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_round_robin();
    test_back_pressure();
    test_credit_exhaust();
    test_credit_saturate();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
